// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the PWM peripheral.
package pwm_pkg;
  localparam int PRESCALE_DEFAULT = 13;
  localparam int CNT_W_DEFAULT = 8;
  localparam int NUM_CH = 16;
  localparam logic [7:0] DUTY_FULL = 8'hFF;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk by PRESCALE; tick is high in the clk where the count wraps to 0.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(PRESCALE - 1);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  // prescale count, restarts at 0 on reset so the first tick lands PRESCALE clks after release
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel PWM/static output block sharing one counter and duty.
// Optional macro PWM_DUTY_SHADOW_EN: duty is latched only at period start.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        en_reg_out_7_0,
  input  logic [7:0]        en_reg_out_15_8,
  input  logic [7:0]        en_reg_pwm_7_0,
  input  logic [7:0]        en_reg_pwm_15_8,
  input  logic [7:0]        pwm_duty_cycle,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);
  localparam int CW = CNT_W > 8 ? CNT_W : 8;
  logic tick, wrap, pwm_sig, ps_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] duty;
  logic [NUM_CH-1:0] en_out, en_pwm, out_q, out_d;
  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );
  assign wrap = tick && (cnt_q == '1);
  assign cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_q;
  // shadow duty follows the input only at the wrap so a period never changes shape mid-way
  always_ff @(posedge clk)
    if (!rst_n) duty_q <= '0;
    else if (wrap) duty_q <= pwm_duty_cycle;
  assign duty = duty_q;
`else
  assign duty = pwm_duty_cycle;
`endif
  assign pwm_sig = (duty == DUTY_FULL) || (CW'(cnt_q) < CW'(duty));
  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign out_d = en_out & (~en_pwm | {NUM_CH{pwm_sig}});
  // shared counter, registered outputs and period-start pulse
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      ps_q  <= wrap;
    end
  assign out = out_q;
  assign period_start = ps_q;
endmodule
